// File: rtl/stall_ctrl.sv
// Pipeline stall controller: zero-latency stall vector from ID/EX/MEM
// requests, plus run length, saturating stall/bubble counters and a watchdog.
module stall_ctrl #(
  parameter int CNT_W      = 32,
  parameter int RUN_W      = 8,
  parameter int WDOG_LIMIT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             clr_stat,
  output logic [5:0]       stall,
  output logic             stall_active,
  output logic [RUN_W-1:0] run_len,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic             stall_timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] WDOG_M1 = RUN_W'(WDOG_LIMIT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_nxt;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_bubbles;
  logic             r_timeout;
  logic [5:0]       w_stall;
  logic             w_any;

  // Deepest requester wins; reset forces release.
  always_comb begin
    w_stall = 6'b000000;
    if (!rst_n)
      w_stall = 6'b000000;
    else if (stallreq_mem)
      w_stall = 6'b011111;
    else if (stallreq_ex)
      w_stall = 6'b001111;
    else if (stallreq_id)
      w_stall = 6'b000111;
  end

  assign w_any = |w_stall;

  always_comb begin
    w_next    = r_state;
    w_run_nxt = '0;
    unique case (r_state)
      IDLE: if (w_any) w_next = RUN;
      RUN:  if (!w_any) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_any)
      w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_run     <= '0;
      r_cycles  <= '0;
      r_bubbles <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= w_run_nxt;
      if (clr_stat) begin
        r_cycles  <= '0;
        r_bubbles <= '0;
        r_timeout <= 1'b0;
      end else begin
        if (w_any && r_cycles != CNT_MAX)
          r_cycles <= r_cycles + 1'b1;
        if (w_any && r_bubbles != CNT_MAX)
          r_bubbles <= r_bubbles + 1'b1;
        if (w_any && r_run == WDOG_M1)
          r_timeout <= 1'b1;
      end
    end
  end

  assign stall         = w_stall;
  assign stall_active  = (r_state == RUN);
  assign run_len       = r_run;
  assign stall_cycles  = r_cycles;
  assign bubble_cnt    = r_bubbles;
  assign stall_timeout = r_timeout;

endmodule
